// File: rtl/genie_loader.sv
// Cheat-file loader: assembles 16-byte records from the download stream, buffers them
// in a 2-entry FIFO and presents each as a code word with a low-high-low strobe.
module genie_loader #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cheat_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [37:0] code,
  output logic        codes_clear,
  output logic        overflow
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef struct packed {
    logic        cmp_en;
    logic [15:0] addr;
    logic [7:0]  compare;
    logic [7:0]  replace;
  } rec_t;

  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;

  logic          dl_q;
  logic          rise, fall, accept, push_req, push, pop, full;
  rec_t          asm_q, asm_d;
  rec_t          mem_q [2];
  rec_t          mem_d [2];
  logic          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          codes_clear_q, codes_clear_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;
  logic          enable_q, enable_d;
  rec_t          fields_q, fields_d;
  logic          unused_addr;

  assign unused_addr = ^ioctl_addr[24:4];

  assign rise     = cheat_download & ~dl_q;
  assign fall     = ~cheat_download & dl_q;
  assign accept   = ioctl_wr & cheat_download;
  assign push_req = accept & (ioctl_addr[3:0] == 4'hF) & ~rise;
  assign full     = (count_q == 2'd2);
  assign pop      = (state_q == IDLE) & (count_q != 2'd0) & ~rise;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign push     = push_req & (~full | pop);

  assign ioctl_wait  = full;
  assign code        = {3'b000, strobe_q, enable_q, fields_q};
  assign codes_clear = codes_clear_q;
  assign overflow    = overflow_q;

  always_comb begin
    asm_d         = asm_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q | (push_req & full & ~pop);
    codes_clear_d = rise;

    if (rise || fall)
      asm_d = '0;
    if (accept) begin
      case (ioctl_addr[3:0])
        4'd0:    asm_d.cmp_en     = ioctl_dout[0];
        4'd4:    asm_d.addr[7:0]  = ioctl_dout;
        4'd5:    asm_d.addr[15:8] = ioctl_dout;
        4'd8:    asm_d.compare    = ioctl_dout;
        4'd12:   asm_d.replace    = ioctl_dout;
        default: ;
      endcase
    end

    if (push) begin
      mem_d[wr_ptr_q] = asm_q;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop)
      rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (rise) begin
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      count_d    = 2'd0;
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    enable_d = enable_q;
    fields_d = fields_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          fields_d = mem_q[rd_ptr_q];
          enable_d = 1'b1;
          strobe_d = 1'b1;
          cnt_d    = CW'(HOLD_CYCLES - 1);
          state_d  = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          strobe_d = 1'b0;
          state_d  = GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        strobe_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new download abandons the code in flight but keeps its fields on the bus.
    if (rise) begin
      state_d  = IDLE;
      strobe_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_q          <= 1'b0;
      asm_q         <= '0;
      mem_q[0]      <= '0;
      mem_q[1]      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      overflow_q    <= 1'b0;
      codes_clear_q <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      strobe_q      <= 1'b0;
      enable_q      <= 1'b0;
      fields_q      <= '0;
    end else begin
      dl_q          <= cheat_download;
      asm_q         <= asm_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      codes_clear_q <= codes_clear_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      strobe_q      <= strobe_d;
      enable_q      <= enable_d;
      fields_q      <= fields_d;
    end
  end

endmodule
